// File: rtl/ntt_core_arbiter_pkg.sv
// Shared constants and FSM state type for the NTT core arbiter.
// POLY_BITS mirrors the Dilithium polynomial bus: 256 coefficients of 32 bits.
package ntt_core_arbiter_pkg;

  localparam int unsigned N_COEF    = 256;
  localparam int unsigned COEF_W    = 32;
  localparam int unsigned POLY_BITS = N_COEF * COEF_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ntt_core_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N_REQ.
// Built as a double-width rotate followed by a find-first-set on the rotated vector.
module rr_priority_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0]  ptr_eff;
  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  sel;
  logic [ID_W:0]    sum;

  always_comb begin
    // An out-of-range pointer falls back to client 0.
    ptr_eff = ({1'b0, ptr} < (ID_W+1)'(N_REQ)) ? ptr : '0;
    rot     = N_REQ'({req, req} >> ptr_eff);
    sel     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (rot[N_REQ-1-k]) begin
        sel = ID_W'(N_REQ - 1 - k);
      end
    end
    sum = {1'b0, ptr_eff} + {1'b0, sel};
    if (sum >= (ID_W+1)'(N_REQ)) begin
      sum = sum - (ID_W+1)'(N_REQ);
    end
    found = |req;
    idx   = sum[ID_W-1:0];
  end

endmodule

// File: rtl/ntt_core_arbiter.sv
// Round-robin arbiter sharing one parallel NTT core between N_REQ clients.
// Latches the winner's operand, runs the core start/done handshake and returns a registered result.
module ntt_core_arbiter
  import ntt_core_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned POLY_W = POLY_BITS,
  parameter int unsigned ID_W   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*POLY_W-1:0] req_poly,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic [ID_W-1:0]         owner_id,
  output logic [N_REQ-1:0]        rsp_done,
  output logic [POLY_W-1:0]       rsp_poly,
  output logic                    core_start,
  output logic [POLY_W-1:0]       core_inp,
  input  logic [POLY_W-1:0]       core_out,
  input  logic                    core_done
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [POLY_W-1:0] core_inp_q, core_inp_d;
  logic [POLY_W-1:0] rsp_poly_q, rsp_poly_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [POLY_W-1:0] win_poly;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (win_found),
    .idx   (win_idx)
  );

  always_comb begin
    win_poly = req_poly[POLY_W*win_idx +: POLY_W];
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    core_inp_d = core_inp_q;
    rsp_poly_d = rsp_poly_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          owner_d    = win_idx;
          grant_d    = N_REQ'(1) << win_idx;
          core_inp_d = win_poly;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          rsp_poly_d = core_out;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d = (owner_q >= ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d  = '0;
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Hold off the next job until the core has dropped done.
        if (!core_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      core_inp_q <= '0;
      rsp_poly_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      core_inp_q <= core_inp_d;
      rsp_poly_q <= rsp_poly_d;
    end
  end

  // grant_q is still set during RESP, so it doubles as the completion pulse pattern.
  assign rsp_done   = (state_q == ST_RESP) ? grant_q : '0;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign owner_id   = owner_q;
  assign core_start = (state_q == ST_RUN);
  assign core_inp   = core_inp_q;
  assign rsp_poly   = rsp_poly_q;

endmodule

// File: tb/tb_ntt_core_arbiter.sv
// Bench for ntt_core_arbiter: core model with programmable latency/done-hold, directed
// scenarios and randomized traffic checked against a round-robin reference model.
module tb_ntt_core_arbiter;

  localparam int N  = 3;
  localparam int PW = 8192;
  localparam int IW = 3;
  localparam logic [PW-1:0] MASK = {256{32'hA5A5_A5A5}};

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*PW-1:0] req_poly = '0;
  logic [N-1:0]    grant;
  logic            busy;
  logic [IW-1:0]   owner_id;
  logic [N-1:0]    rsp_done;
  logic [PW-1:0]   rsp_poly;
  logic            core_start;
  logic [PW-1:0]   core_inp;
  logic [PW-1:0]   core_out;
  logic            core_done;

  int vectors = 0;
  int miscompares = 0;
  int lat = 5;
  int hold = 1;
  int m_ptr = 0;
  logic [PW-1:0] ops [N];

  ntt_core_arbiter #(
    .N_REQ  (N),
    .POLY_W (PW),
    .ID_W   (IW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_poly   (req_poly),
    .grant      (grant),
    .busy       (busy),
    .owner_id   (owner_id),
    .rsp_done   (rsp_done),
    .rsp_poly   (rsp_poly),
    .core_start (core_start),
    .core_inp   (core_inp),
    .core_out   (core_out),
    .core_done  (core_done)
  );

  always #5 clock = ~clock;

  // Core model: done rises in the lat-th cycle of start and stays high for hold cycles.
  int cnt, hcnt;
  always @(posedge clock) begin
    if (reset) begin
      core_done <= 1'b0;
      core_out  <= '0;
      cnt       <= 0;
      hcnt      <= 0;
    end else if (core_done) begin
      if (hcnt <= 1) begin
        core_done <= 1'b0;
        hcnt      <= 0;
      end else begin
        hcnt <= hcnt - 1;
      end
    end else if (core_start) begin
      if (cnt == lat - 2) begin
        core_done <= 1'b1;
        core_out  <= core_inp ^ MASK;
        hcnt      <= hold;
        cnt       <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i);
    for (int w = 0; w < PW / 32; w++) ops[i][32*w +: 32] = $urandom();
    req_poly[PW*i +: PW] = ops[i];
  endtask

  function automatic int exp_winner(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0 && o < N) v[o] = 1'b1;
    return v;
  endfunction

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (rsp_done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    vectors++; if (grant !== '0) begin miscompares++; $display("FAIL reset_grant: got %b expected 000", grant); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (owner_id !== '0) begin miscompares++; $display("FAIL reset_owner: got %0d expected 0", owner_id); end
    vectors++; if (rsp_done !== '0) begin miscompares++; $display("FAIL reset_rsp_done: got %b expected 000", rsp_done); end
    vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL reset_core_start: got %b expected 0", core_start); end
    vectors++; if (core_inp !== '0) begin miscompares++; $display("FAIL reset_core_inp: got %h expected 0", core_inp[63:0]); end
    vectors++; if (rsp_poly !== '0) begin miscompares++; $display("FAIL reset_rsp_poly: got %h expected 0", rsp_poly[63:0]); end
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single();
    int nstart;
    bit ok;
    lat = 5; hold = 1;
    set_op(1);
    req = 3'b010;
    tick();
    vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL single_grant: got %b expected 010", grant); end
    vectors++; if (core_start !== 1'b1) begin miscompares++; $display("FAIL single_start: got %b expected 1", core_start); end
    vectors++; if (owner_id !== 3'd1) begin miscompares++; $display("FAIL single_owner: got %0d expected 1", owner_id); end
    vectors++; if (core_inp !== ops[1]) begin miscompares++; $display("FAIL single_core_inp: got %h expected %h", core_inp[63:0], ops[1][63:0]); end
    nstart = 1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (rsp_done !== '0) begin ok = 1'b1; break; end
      if (core_start === 1'b1) nstart++;
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout: got no rsp_done expected one within 50 cycles"); end
    vectors++; if (nstart != 5) begin miscompares++; $display("FAIL single_start_len: got %0d expected 5", nstart); end
    vectors++; if (rsp_done !== 3'b010) begin miscompares++; $display("FAIL single_rsp_done: got %b expected 010", rsp_done); end
    vectors++; if (rsp_poly !== (ops[1] ^ MASK)) begin miscompares++; $display("FAIL single_rsp_poly: got %h expected %h", rsp_poly[63:0], (ops[1] ^ MASK) & 64'hFFFF_FFFF_FFFF_FFFF); end
    req = '0;
    tick();
    vectors++; if (rsp_done !== '0) begin miscompares++; $display("FAIL single_pulse_len: got %b expected 000", rsp_done); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_drain_busy: got %b expected 1", busy); end
    tick();
    vectors++; if (busy !== 1'b0 || grant !== '0) begin miscompares++; $display("FAIL single_idle: got busy=%b grant=%b expected busy=0 grant=000", busy, grant); end
    m_ptr = 2;
  endtask

  task automatic test_round_robin();
    int jobs, e;
    reset = 1'b1; tick(); reset = 1'b0;
    m_ptr = 0;
    lat = 3; hold = 1;
    for (int i = 0; i < N; i++) set_op(i);
    req  = 3'b111;
    jobs = 0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (rsp_done !== '0) begin
        e = exp_winner(req, m_ptr);
        vectors++; if (rsp_done !== onehot(e)) begin miscompares++; $display("FAIL rr_order: got %b expected %b", rsp_done, onehot(e)); end
        vectors++; if (rsp_poly !== (ops[e] ^ MASK)) begin miscompares++; $display("FAIL rr_result: got %h expected %h", rsp_poly[63:0], (ops[e] ^ MASK) & 64'hFFFF_FFFF_FFFF_FFFF); end
        vectors++; if (c != 4 + 6 * jobs) begin miscompares++; $display("FAIL rr_timing: got cycle %0d expected %0d", c, 4 + 6 * jobs); end
        jobs++;
        m_ptr = (e + 1) % N;
      end
    end
    req = '0;
    vectors++; if (jobs != 6) begin miscompares++; $display("FAIL rr_job_count: got %0d expected 6", jobs); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_end_idle: got %b expected 0", busy); end
  endtask

  task automatic test_fairness();
    int cyc;
    bit ok;
    lat = 3; hold = 1;
    set_op(0); set_op(2);
    req = 3'b001;
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== 3'b001) begin miscompares++; $display("FAIL fair_first: got %b expected 001", rsp_done); end
    m_ptr = 1;
    req = 3'b101;
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== onehot(exp_winner(3'b101, m_ptr))) begin miscompares++; $display("FAIL fair_other_first: got %b expected %b", rsp_done, onehot(exp_winner(3'b101, m_ptr))); end
    m_ptr = 0;
    req = 3'b001;
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== 3'b001) begin miscompares++; $display("FAIL fair_return: got %b expected 001", rsp_done); end
    req = '0;
    tick(); tick();
    m_ptr = 1;
  endtask

  task automatic test_drop_mid_run();
    logic [PW-1:0] orig;
    int cyc;
    bit ok;
    lat = 5; hold = 1;
    set_op(1);
    orig = ops[1];
    req = 3'b010;
    tick();
    set_op(1);
    req = '0;
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== 3'b010) begin miscompares++; $display("FAIL drop_rsp_done: got %b expected 010", rsp_done); end
    vectors++; if (rsp_poly !== (orig ^ MASK)) begin miscompares++; $display("FAIL drop_result: got %h expected %h", rsp_poly[63:0], (orig ^ MASK) & 64'hFFFF_FFFF_FFFF_FFFF); end
    set_op(0);
    req = 3'b001;
    tick();
    vectors++; if (grant !== '0 || core_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL drop_drain: got grant=%b start=%b busy=%b expected 000 0 1", grant, core_start, busy); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got %b expected 0", busy); end
    tick();
    vectors++; if (grant !== 3'b001 || core_start !== 1'b1) begin miscompares++; $display("FAIL drop_next_grant: got grant=%b start=%b expected 001 1", grant, core_start); end
    vectors++; if (core_inp !== ops[0]) begin miscompares++; $display("FAIL drop_next_inp: got %h expected %h", core_inp[63:0], ops[0][63:0]); end
    req = '0;
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== 3'b001) begin miscompares++; $display("FAIL drop_next_done: got %b expected 001", rsp_done); end
    tick(); tick();
    m_ptr = 1;
  endtask

  task automatic test_reset_mid_run();
    int cyc, e;
    bit ok;
    lat = 5; hold = 1;
    set_op(2);
    req = 3'b100;
    tick(); tick();
    reset = 1'b1;
    tick();
    vectors++; if (core_start !== 1'b0 || grant !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_run_state: got start=%b grant=%b busy=%b expected 0 000 0", core_start, grant, busy); end
    vectors++; if (rsp_done !== '0 || owner_id !== '0) begin miscompares++; $display("FAIL rst_run_outputs: got done=%b owner=%0d expected 000 0", rsp_done, owner_id); end
    reset = 1'b0;
    req = '0;
    m_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (rsp_done !== '0) begin miscompares++; $display("FAIL rst_spurious_done: got %b expected 000", rsp_done); end
    end
    set_op(0); set_op(2);
    req = 3'b101;
    e = exp_winner(3'b101, m_ptr);
    tick();
    vectors++; if (grant !== onehot(e)) begin miscompares++; $display("FAIL rst_ptr_zero: got %b expected %b", grant, onehot(e)); end
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== onehot(e)) begin miscompares++; $display("FAIL rst_reissue_done: got %b expected %b", rsp_done, onehot(e)); end
    vectors++; if (rsp_poly !== (ops[e] ^ MASK)) begin miscompares++; $display("FAIL rst_reissue_result: got %h expected %h", rsp_poly[63:0], (ops[e] ^ MASK) & 64'hFFFF_FFFF_FFFF_FFFF); end
    req = '0;
    tick(); tick();
    m_ptr = (e + 1) % N;
  endtask

  task automatic test_done_hold();
    int cyc;
    bit ok;
    lat = 3; hold = 3;
    set_op(1);
    req = 3'b010;
    wait_done(cyc, ok);
    vectors++; if (!ok || rsp_done !== 3'b010) begin miscompares++; $display("FAIL hold_rsp_done: got %b expected 010", rsp_done); end
    req = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++; if (rsp_done !== '0 || core_start !== 1'b0) begin miscompares++; $display("FAIL hold_spurious: got done=%b start=%b expected 000 0", rsp_done, core_start); end
      vectors++; if (busy !== (k < 2)) begin miscompares++; $display("FAIL hold_drain_busy: got %b expected %b at step %0d", busy, (k < 2), k); end
    end
    hold = 1;
    m_ptr = 2;
  endtask

  task automatic test_random_traffic();
    logic [N-1:0]  prev_req;
    logic          prev_busy;
    logic [PW-1:0] exp_val;
    int            exp_owner, jobs;
    exp_owner = -1;
    exp_val   = '0;
    jobs      = 0;
    prev_req  = req;
    prev_busy = busy;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        exp_owner = exp_winner(prev_req, m_ptr);
        exp_val   = (exp_owner >= 0) ? (ops[exp_owner] ^ MASK) : '0;
        vectors++; if (grant !== onehot(exp_owner)) begin miscompares++; $display("FAIL rand_grant: got %b expected %b", grant, onehot(exp_owner)); end
      end
      if (rsp_done !== '0) begin
        vectors++; if (rsp_done !== onehot(exp_owner)) begin miscompares++; $display("FAIL rand_rsp_done: got %b expected %b", rsp_done, onehot(exp_owner)); end
        vectors++; if (rsp_poly !== exp_val) begin miscompares++; $display("FAIL rand_result: got %h expected %h", rsp_poly[63:0], exp_val[63:0]); end
        if (exp_owner >= 0) begin
          m_ptr = (exp_owner + 1) % N;
          if ($urandom_range(1, 0) == 0) req[exp_owner] = 1'b0;
          else set_op(exp_owner);
        end
        jobs++;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req[i] == 1'b0 && $urandom_range(3, 0) == 0) begin
            set_op(i);
            req[i] = 1'b1;
          end
        end
      end
      if (busy === 1'b0) begin
        lat  = $urandom_range(6, 2);
        hold = $urandom_range(3, 1);
      end
      prev_req  = req;
      prev_busy = busy;
    end
    req = '0;
    for (int c = 0; c < 100 && busy !== 1'b0; c++) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand_drain: got busy=%b expected 0", busy); end
    vectors++; if (jobs < 10) begin miscompares++; $display("FAIL rand_job_count: got %0d expected at least 10", jobs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_drop_mid_run();
    test_reset_mid_run();
    test_done_hold();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
